// File: rtl/key_led_mode_ctrl.sv
// Key-driven LED mode controller: three bouncing active-low keys are synchronised,
// debounced and arbitrated into single press events that step an OFF/ON/SLOW/FAST mode FSM.
module key_led_mode_ctrl #(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int SLOW_HALF  = 25_000_000,
    parameter int FAST_HALF  = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       m_key1,
    input  logic       m_key2,
    input  logic       m_key3,
    output logic       m_led,
    output logic [1:0] m_mode,
    output logic [2:0] m_key_evt
);

    localparam int DW       = $clog2(DEB_CYCLES + 1);
    localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int BW       = $clog2(MAX_HALF + 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    logic [2:0]    key_raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_prev;
    logic [DW-1:0] deb_cnt [3];
    logic [2:0]    press;
    logic [2:0]    winner;

    mode_t         state;
    mode_t         state_nxt;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] half_last;
    logic          phase;
    logic          led_nxt;

    assign key_raw = {m_key3, m_key2, m_key1};

    // Keys idle high, so every key flop resets to the released level.
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1       <= 3'b111;
            sync2       <= 3'b111;
            stable      <= 3'b111;
            stable_prev <= 3'b111;
            // NOTE: the debounce counters are a tiny register array, so they are reset like any flop.
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1       <= key_raw;
            sync2       <= sync1;
            stable_prev <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Falling edge of the debounced level is a press; lower-priority presses in the same cycle are dropped.
    always_comb begin
        press  = stable_prev & ~stable;
        winner = 3'b000;
        if (press[0])      winner = 3'b001;
        else if (press[1]) winner = 3'b010;
        else if (press[2]) winner = 3'b100;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m_key_evt <= 3'b000;
        else            m_key_evt <= winner;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= MODE_OFF;
        else            state <= state_nxt;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        if (m_key_evt[0]) begin
            state_nxt = (state == MODE_OFF) ? MODE_ON : MODE_OFF;
        end else if (m_key_evt[1]) begin
            state_nxt = (state == MODE_SLOW) ? MODE_FAST : MODE_SLOW;
        end else if (m_key_evt[2]) begin
            state_nxt = mode_t'(state + 2'd1);
        end
    end

    always_comb begin
        m_mode  = state;
        led_nxt = 1'b0;
        case (state)
            MODE_OFF:  led_nxt = 1'b0;
            MODE_ON:   led_nxt = 1'b1;
            MODE_SLOW,
            MODE_FAST: led_nxt = phase;
            default:   led_nxt = 1'b0;
        endcase
    end

    assign half_last = (state == MODE_FAST) ? BW'(FAST_HALF - 1) : BW'(SLOW_HALF - 1);

    // Restart the timer on mode change so every blink mode opens with a full LED-on half period.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (state_nxt != state) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (state == MODE_SLOW || state == MODE_FAST) begin
            if (blink_cnt == half_last) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m_led <= 1'b0;
        else            m_led <= led_nxt;
    end

endmodule

// File: tb/tb_key_led_mode_ctrl.sv
// Directed bench for key_led_mode_ctrl with short debounce and blink periods.
module tb_key_led_mode_ctrl;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       k1, k2, k3;
    logic       m_led;
    logic [1:0] m_mode;
    logic [2:0] m_key_evt;

    int errors = 0;
    int checks = 0;

    // Per-step history of the last run(); index 1 is the sample after the first edge.
    logic [2:0] evt_h  [1:40];
    logic [1:0] mode_h [1:40];
    logic       led_h  [1:40];
    int         nevt;
    int         first_evt;

    key_led_mode_ctrl #(
        .DEB_CYCLES(4),
        .SLOW_HALF (8),
        .FAST_HALF (3)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .m_key1   (k1),
        .m_key2   (k2),
        .m_key3   (k3),
        .m_led    (m_led),
        .m_mode   (m_mode),
        .m_key_evt(m_key_evt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic run(input int n);
        nevt      = 0;
        first_evt = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge sys_clk);
            #1;
            evt_h[i]  = m_key_evt;
            mode_h[i] = m_mode;
            led_h[i]  = m_led;
            if (m_key_evt != 3'b000) begin
                nevt++;
                if (first_evt == 0) first_evt = i;
            end
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            1: k1 = v;
            2: k2 = v;
            default: k3 = v;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b0);
        run(15);
        set_key(k, 1'b1);
        run(15);
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
        #2;
        checks++; if (m_mode !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", m_mode); end
        checks++; if (m_led !== 1'b0) begin errors++; $display("FAIL reset_led: got %0b expected 0", m_led); end
        checks++; if (m_key_evt !== 3'b000) begin errors++; $display("FAIL reset_evt: got %b expected 000", m_key_evt); end
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        run(10);
        checks++; if (nevt !== 0) begin errors++; $display("FAIL idle_evt: got %0d events expected 0", nevt); end
    endtask

    task automatic test_press_key1;
        k1 = 1'b0;
        run(20);
        checks++; if (nevt !== 1) begin errors++; $display("FAIL press1_count: got %0d expected 1", nevt); end
        checks++; if (first_evt !== 7) begin errors++; $display("FAIL press1_latency: got %0d expected 7", first_evt); end
        checks++; if (evt_h[7] !== 3'b001) begin errors++; $display("FAIL press1_evt: got %b expected 001", evt_h[7]); end
        checks++; if (mode_h[7] !== 2'd0) begin errors++; $display("FAIL press1_mode_early: got %0d expected 0", mode_h[7]); end
        checks++; if (mode_h[8] !== 2'd1) begin errors++; $display("FAIL press1_mode: got %0d expected 1", mode_h[8]); end
        checks++; if (led_h[8] !== 1'b0) begin errors++; $display("FAIL press1_led_early: got %0b expected 0", led_h[8]); end
        checks++; if (led_h[9] !== 1'b1) begin errors++; $display("FAIL press1_led: got %0b expected 1", led_h[9]); end
        k1 = 1'b1;
        run(20);
        checks++; if (nevt !== 0) begin errors++; $display("FAIL release_evt: got %0d events expected 0", nevt); end
        checks++; if (m_mode !== 2'd1) begin errors++; $display("FAIL release_mode: got %0d expected 1", m_mode); end
        press(1);
        checks++; if (m_mode !== 2'd0) begin errors++; $display("FAIL back_to_off: got %0d expected 0", m_mode); end
    endtask

    task automatic test_bounce;
        int total;
        int led_seen;
        total    = 0;
        led_seen = 0;
        k1 = 1'b0; run(3); total += nevt;
        k1 = 1'b1; run(1); total += nevt;
        k1 = 1'b0; run(3); total += nevt;
        k1 = 1'b1; run(1); total += nevt;
        run(20); total += nevt;
        for (int i = 1; i <= 20; i++) if (led_h[i] !== 1'b0) led_seen++;
        checks++; if (total !== 0) begin errors++; $display("FAIL bounce_evt: got %0d events expected 0", total); end
        checks++; if (m_mode !== 2'd0) begin errors++; $display("FAIL bounce_mode: got %0d expected 0", m_mode); end
        checks++; if (led_seen !== 0) begin errors++; $display("FAIL bounce_led: got %0d lit samples expected 0", led_seen); end
    endtask

    task automatic test_blink;
        logic exp;
        int   bad;
        k2 = 1'b0;
        run(32);
        checks++; if (mode_h[8] !== 2'd2) begin errors++; $display("FAIL slow_mode: got %0d expected 2", mode_h[8]); end
        bad = 0;
        for (int i = 9; i <= 32; i++) begin
            exp = (i <= 16 || i >= 25);
            if (led_h[i] !== exp) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL slow_pattern: got %0d wrong samples expected 0", bad); end
        k2 = 1'b1;
        run(10);
        k2 = 1'b0;
        run(20);
        checks++; if (mode_h[8] !== 2'd3) begin errors++; $display("FAIL fast_mode: got %0d expected 3", mode_h[8]); end
        bad = 0;
        for (int i = 9; i <= 20; i++) begin
            exp = (((i - 9) / 3) % 2) == 0;
            if (led_h[i] !== exp) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL fast_pattern: got %0d wrong samples expected 0", bad); end
        k2 = 1'b1;
        run(10);
        press(1);
        checks++; if (m_mode !== 2'd0) begin errors++; $display("FAIL fast_to_off: got %0d expected 0", m_mode); end
    endtask

    task automatic test_priority;
        k1 = 1'b0;
        k3 = 1'b0;
        run(30);
        checks++; if (nevt !== 1) begin errors++; $display("FAIL prio_count: got %0d expected 1", nevt); end
        checks++; if (evt_h[7] !== 3'b001) begin errors++; $display("FAIL prio_evt: got %b expected 001", evt_h[7]); end
        checks++; if (m_mode !== 2'd1) begin errors++; $display("FAIL prio_mode: got %0d expected 1", m_mode); end
        k1 = 1'b1;
        k3 = 1'b1;
        run(15);
        press(1);
    endtask

    task automatic test_key3_cycle;
        logic [1:0] exp_seq [4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int n = 0; n < 4; n++) begin
            press(3);
            checks++;
            if (m_mode !== exp_seq[n]) begin
                errors++;
                $display("FAIL key3_step%0d: got %0d expected %0d", n, m_mode, exp_seq[n]);
            end
        end
        checks++; if (m_led !== 1'b0) begin errors++; $display("FAIL key3_led: got %0b expected 0", m_led); end
    endtask

    task automatic test_reset_mid;
        press(2);
        press(2);
        checks++; if (m_mode !== 2'd3) begin errors++; $display("FAIL pre_reset_mode: got %0d expected 3", m_mode); end
        k2 = 1'b0;
        run(3);
        sys_rst_n = 1'b0;
        #2;
        checks++; if (m_mode !== 2'd0) begin errors++; $display("FAIL midrst_mode: got %0d expected 0", m_mode); end
        checks++; if (m_led !== 1'b0) begin errors++; $display("FAIL midrst_led: got %0b expected 0", m_led); end
        checks++; if (m_key_evt !== 3'b000) begin errors++; $display("FAIL midrst_evt: got %b expected 000", m_key_evt); end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        run(12);
        checks++; if (nevt !== 1) begin errors++; $display("FAIL postrst_count: got %0d expected 1", nevt); end
        checks++; if (first_evt !== 7) begin errors++; $display("FAIL postrst_latency: got %0d expected 7", first_evt); end
        checks++; if (evt_h[7] !== 3'b010) begin errors++; $display("FAIL postrst_evt: got %b expected 010", evt_h[7]); end
        checks++; if (mode_h[8] !== 2'd2) begin errors++; $display("FAIL postrst_mode: got %0d expected 2", mode_h[8]); end
        k2 = 1'b1;
        run(10);
    endtask

    initial begin
        test_reset;
        test_press_key1;
        test_bounce;
        test_blink;
        test_priority;
        test_key3_cycle;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_led_mode_ctrl.md
Name: key_led_mode_ctrl

Overview:
- Board-level controller that converts three raw, bouncing, active-low push keys into a debounced LED mode sequencer.
- Modes: off, on, slow blink, fast blink.
- Contains per-key synchroniser and debouncer, one-cycle press-event detection, fixed-priority arbitration of simultaneous presses, and a 4-state mode FSM with a blink timer.
- Sits directly between the board key pins and the LED pin; it replaces the purely combinational key-to-LED gating.

Parameters:
- DEB_CYCLES, 1_000_000: consecutive sys_clk cycles a synchronised key must differ from its stable value before the stable value updates (20 ms at 50 MHz).
- SLOW_HALF, 25_000_000: sys_clk cycles per half-period in slow blink mode.
- FAST_HALF, 5_000_000: sys_clk cycles per half-period in fast blink mode.

Ports:
- sys_clk, input, 1: system clock, single clock domain.
- sys_rst_n, input, 1: asynchronous active-low reset.
- m_key1, input, 1: raw key 1, active-low (0 = pressed), asynchronous.
- m_key2, input, 1: raw key 2, active-low, asynchronous.
- m_key3, input, 1: raw key 3, active-low, asynchronous.
- m_led, output, 1: LED drive, active-high, registered.
- m_mode, output, 2: current mode. 0 = OFF, 1 = ON, 2 = SLOW, 3 = FAST.
- m_key_evt, output, 3: one-cycle accepted-press pulse. Bit0 = key1, bit2 = key3. At most one bit is high.

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - Synchroniser flops = 1; stable key values = 1 (released); debounce counters = 0.
  - m_key_evt = 0; m_mode = OFF; blink counter = 0; blink phase = 1; m_led = 0.
- Synchroniser: two flops per key, reset to 1.
- Debounce, per key:
  - If sync == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach DEB_CYCLES, stable <= sync and the counter clears.
  - A single matching sample during counting restarts the count. Bounces shorter than DEB_CYCLES are rejected.
- Press detect: press = stable_prev 1 and stable 0, evaluated one cycle after stable changes. Releases generate no event.
- Arbitration:
  - If several presses occur in the same cycle, priority is key1 > key2 > key3.
  - Lower-priority simultaneous presses are dropped, not queued.
  - The winner is registered into m_key_evt for exactly one cycle.
- FSM, updated on the cycle after m_key_evt (m_mode registered):
  - key1: OFF -> ON; ON, SLOW or FAST -> OFF.
  - key2: OFF or ON -> SLOW; SLOW -> FAST; FAST -> SLOW.
  - key3: cycles OFF -> ON -> SLOW -> FAST -> OFF.
  - No event: hold the current mode.
- Blink timer:
  - On any m_mode change: counter = 0, phase = 1.
  - In SLOW or FAST: counter counts 0..HALF-1. At HALF-1 it wraps to 0 and phase toggles.
  - HALF is SLOW_HALF or FAST_HALF according to mode.
  - In OFF or ON: counter held at 0, phase held at 1.
- m_led (registered, one cycle after m_mode/phase):
  - OFF -> 0.
  - ON -> 1.
  - SLOW or FAST -> phase.
  - The first blink half-period after mode entry is LED on.
- End-to-end latency: 2 (sync) + DEB_CYCLES (debounce) + 1 (event) + 1 (mode) + 1 (led).
- A key held low through reset release yields a press event after the debounce period. This is intended.
- Reset mid-operation: all state returns to reset values immediately. Partial debounce counts are discarded.

Test Plan (DEB_CYCLES=4, SLOW_HALF=8, FAST_HALF=3):
- Reset, then clean m_key1 press held 20 cycles:
  - m_key_evt = 001 for exactly one cycle, 2+4+1 cycles after the edge.
  - m_mode 0 -> 1 on the next cycle; m_led = 1 one cycle later.
  - Release: no event.
- m_key1 bounce pattern low 3, high 1, low 3, high 1, then released:
  - No m_key_evt.
  - m_mode stays 0; m_led stays 0.
- From OFF, press m_key2:
  - m_mode = 2.
  - m_led pattern: 1 for 8 cycles, 0 for 8, 1 for 8.
  - Press m_key2 again: m_mode = 3, m_led toggles every 3 cycles, starting with 1.
- m_key1 and m_key3 pressed in the same cycle from OFF:
  - m_key_evt = 001 only; m_mode = 1.
  - No key3 event afterwards while both are held.
- Four successive m_key3 presses from OFF: m_mode sequence 1, 2, 3, 0; final m_led = 0.
- In FAST mode, assert sys_rst_n low for 1 cycle mid-debounce of m_key2:
  - Outputs immediately m_mode = 0, m_led = 0, m_key_evt = 0.
  - With m_key2 still held, one press event follows 2+4+1 cycles after release.
